// File: rtl/fp_pkg.sv
// Shared definitions for the FP execute-stage helper blocks.
//   - FSM state encoding for the integer-to-float converter
//   - rounding-mode encodings (RNE, RTZ, RDN, RUP, RMM)
//   - binary32 exponent bias and a packed binary32 view
package fp_pkg;

  localparam int FP32_BIAS = 127;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] fraction;
  } fp32_t;

endpackage

// File: rtl/fp_round_unit.sv
// Combinational rounding/packing stage for a normalised 32-bit magnitude.
// Ports:
//   sign     in  1   result sign
//   mag      in  32  normalised magnitude (bit 31 set unless the value is zero)
//   shift    in  5   left-shift count applied during normalisation
//   rm       in  3   rounding mode; unknown encodings round to nearest-even
//   result   out 32  packed binary32 value
//   inexact  out 1   discarded bits were non-zero
module fp_round_unit
  import fp_pkg::*;
#(
  parameter int BIAS = FP32_BIAS
) (
  input  logic        sign,
  input  logic [31:0] mag,
  input  logic [4:0]  shift,
  input  logic [2:0]  rm,
  output logic [31:0] result,
  output logic        inexact
);

  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_sum;
  logic [8:0]  exp_base;
  logic [8:0]  exp_final;
  fp32_t       packed_res;

  always_comb begin
    guard  = mag[7];
    sticky = |mag[6:0];

    case (rm)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sign & (guard | sticky);
      RM_RUP:  round_up = ~sign & (guard | sticky);
      RM_RMM:  round_up = guard;
      default: round_up = guard & (sticky | mag[8]);
    endcase

    // Bit 23 of the sum is the mantissa carry-out; the low 23 bits are then
    // already zero, so only the exponent needs the increment.
    mant_sum  = {1'b0, mag[30:8]} + {23'd0, round_up};
    exp_base  = 9'(BIAS + 31) - {4'd0, shift};
    exp_final = exp_base + {8'd0, mant_sum[23]};

    packed_res.sign     = sign;
    packed_res.exponent = exp_final[7:0];
    packed_res.fraction = mant_sum[22:0];

    if (!mag[31]) begin
      result  = 32'h0000_0000;
      inexact = 1'b0;
    end else begin
      result  = packed_res;
      inexact = guard | sticky;
    end
  end

endmodule

// File: rtl/int_to_float_converter.sv
// FCVT.S.W / FCVT.S.WU: 32-bit integer to binary32, fixed 6-cycle latency.
// Normalisation is a 5-step leading-zero search (widths 16, 8, 4, 2, 1).
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | waiting for START; operand captured on START
//   ST_NORM  | five normalisation steps, one width per cycle
//   ST_ROUND | round, pack and register RESULT / INEXACT
//   ST_FIN   | DONE pulse, then back to idle
//
// Ports:
//   CLK          in  1   clock
//   RESET        in  1   asynchronous active-low reset
//   START        in  1   request strobe, sampled only in idle
//   DATA1        in  32  integer operand
//   UNSIGNED_OP  in  1   1 = unsigned operand, 0 = two's complement
//   RM           in  3   rounding mode
//   BUSY         out 1   converter not idle
//   DONE         out 1   one-cycle completion pulse
//   RESULT       out 32  binary32 result, held until the next DONE
//   INEXACT      out 1   NX flag, held with RESULT
module int_to_float_converter
  import fp_pkg::*;
#(
  parameter int BIAS = FP32_BIAS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] DATA1,
  input  logic        UNSIGNED_OP,
  input  logic [2:0]  RM,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic        INEXACT
);

  logic [1:0]  state;
  logic [2:0]  step;
  logic [31:0] mag;
  logic [4:0]  shift;
  logic        sign;
  logic [2:0]  rm_q;

  logic        operand_neg;
  logic [31:0] operand_mag;
  logic        top_zero;
  logic [31:0] mag_shifted;
  logic [4:0]  shift_add;
  logic [31:0] rnd_result;
  logic        rnd_inexact;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign operand_neg = DATA1[31] & ~UNSIGNED_OP;
  assign operand_mag = operand_neg ? (~DATA1 + 32'd1) : DATA1;

  always_comb begin
    top_zero    = 1'b0;
    mag_shifted = mag;
    shift_add   = 5'd0;
    case (step)
      3'd0: begin
        top_zero    = (mag[31:16] == 16'd0);
        mag_shifted = {mag[15:0], 16'd0};
        shift_add   = 5'd16;
      end
      3'd1: begin
        top_zero    = (mag[31:24] == 8'd0);
        mag_shifted = {mag[23:0], 8'd0};
        shift_add   = 5'd8;
      end
      3'd2: begin
        top_zero    = (mag[31:28] == 4'd0);
        mag_shifted = {mag[27:0], 4'd0};
        shift_add   = 5'd4;
      end
      3'd3: begin
        top_zero    = (mag[31:30] == 2'd0);
        mag_shifted = {mag[29:0], 2'd0};
        shift_add   = 5'd2;
      end
      default: begin
        top_zero    = ~mag[31];
        mag_shifted = {mag[30:0], 1'b0};
        shift_add   = 5'd1;
      end
    endcase
  end

  fp_round_unit #(
    .BIAS (BIAS)
  ) u_round (
    .sign    (sign),
    .mag     (mag),
    .shift   (shift),
    .rm      (rm_q),
    .result  (rnd_result),
    .inexact (rnd_inexact)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      step    <= 3'd0;
      mag     <= 32'd0;
      shift   <= 5'd0;
      sign    <= 1'b0;
      rm_q    <= 3'd0;
      RESULT  <= 32'd0;
      INEXACT <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            sign  <= operand_neg;
            mag   <= operand_mag;
            rm_q  <= RM;
            shift <= 5'd0;
            step  <= 3'd0;
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (top_zero) begin
            mag   <= mag_shifted;
            shift <= shift + shift_add;
          end
          if (step == 3'd4) begin
            step  <= 3'd0;
            state <= ST_ROUND;
          end else begin
            step <= step + 3'd1;
          end
        end
        ST_ROUND: begin
          RESULT  <= rnd_result;
          INEXACT <= rnd_inexact;
          state   <= ST_FIN;
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_FIN);

endmodule

// File: tb/tb_int_to_float_converter.sv
// Self-checking bench for int_to_float_converter: directed vectors with
// literal expectations, an arithmetic reference model, and a per-cycle
// compare of BUSY / DONE / RESULT / INEXACT against that model.
module tb_int_to_float_converter;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [31:0] DATA1;
  logic        UNSIGNED_OP;
  logic [2:0]  RM;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;
  logic        INEXACT;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int          m_k = -1000;
  logic [31:0] m_pres = 32'd0;
  logic        m_pnx = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic        m_nx = 1'b0;

  int_to_float_converter dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .DATA1       (DATA1),
    .UNSIGNED_OP (UNSIGNED_OP),
    .RM          (RM),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .RESULT      (RESULT),
    .INEXACT     (INEXACT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion by plain integer arithmetic: locate the leading one,
  // keep 24 significant bits, round the remainder against half an ulp.
  function automatic void fp_model(input logic [31:0] d, input logic uns, input logic [2:0] rm,
                                   output logic [31:0] res, output logic nx);
    longint unsigned mag, q, rem, half;
    int p, drop;
    bit sgn, up;
    logic [7:0] e8;
    sgn = d[31] && !uns;
    mag = sgn ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
    if (mag == 0) begin
      res = 32'd0;
      nx  = 1'b0;
      return;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (((mag >> i) & 64'd1) != 0) p = i;
    if (p <= 23) begin
      q = mag << (23 - p);
      rem = 0;
      half = 1;
    end else begin
      drop = p - 23;
      q = mag >> drop;
      rem = mag & ((64'd1 << drop) - 1);
      half = 64'd1 << (drop - 1);
    end
    case (rm)
      3'd1: up = 0;
      3'd2: up = sgn && (rem != 0);
      3'd3: up = !sgn && (rem != 0);
      3'd4: up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && ((q & 64'd1) != 0));
    endcase
    if (up) q = q + 1;
    if (q == 64'h100_0000) begin
      q = 64'h80_0000;
      p = p + 1;
    end
    e8 = 8'(127 + p);
    res = {sgn, e8, q[22:0]};
    nx = (rem != 0);
  endfunction

  // Model timeline: a START accepted at edge k gives BUSY after edges k..k+6,
  // DONE after edge k+6, and the next START can be accepted at edge k+8.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_k   = -1000;
      m_res = 32'd0;
      m_nx  = 1'b0;
    end else begin
      if ((cyc + 1 >= m_k + 8) && START) begin
        m_k = cyc + 1;
        fp_model(DATA1, UNSIGNED_OP, RM, m_pres, m_pnx);
      end
      if (cyc + 1 == m_k + 6) begin
        m_res = m_pres;
        m_nx  = m_pnx;
      end
    end
  end

  always @(negedge CLK) begin
    if (cyc > 0) begin
      check("busy", {31'd0, BUSY}, {31'd0, (cyc >= m_k) && (cyc <= m_k + 6)});
      check("done", {31'd0, DONE}, {31'd0, cyc == m_k + 6});
      check("result", RESULT, m_res);
      check("inexact", {31'd0, INEXACT}, {31'd0, m_nx});
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        uns;
    logic [2:0]  rm;
    logic [31:0] res;
    logic        nx;
  } vec_t;

  vec_t vecs [17];

  task automatic convert(input vec_t v, input int idx);
    logic [31:0] mr;
    logic mnx;
    int k;
    bit seen;
    fp_model(v.data, v.uns, v.rm, mr, mnx);
    check($sformatf("model_res[%0d]", idx), mr, v.res);
    check($sformatf("model_nx[%0d]", idx), {31'd0, mnx}, {31'd0, v.nx});
    @(negedge CLK);
    DATA1 = v.data;
    UNSIGNED_OP = v.uns;
    RM = v.rm;
    START = 1'b1;
    k = cyc + 1;
    @(negedge CLK);
    START = 1'b0;
    DATA1 = 32'hDEAD_BEEF;
    UNSIGNED_OP = ~v.uns;
    RM = 3'd3;
    seen = 0;
    for (int i = 0; i < 15 && !seen; i++) begin
      if (DONE) seen = 1;
      else @(negedge CLK);
    end
    if (!seen) begin
      check($sformatf("done_timeout[%0d]", idx), 32'd0, 32'd1);
    end else begin
      check($sformatf("latency[%0d]", idx), 32'(cyc - k), 32'd6);
      check($sformatf("vec_res[%0d]", idx), RESULT, v.res);
      check($sformatf("vec_nx[%0d]", idx), {31'd0, INEXACT}, {31'd0, v.nx});
    end
    @(negedge CLK);
  endtask

  initial begin
    int dones;
    int k;
    START = 1'b0;
    DATA1 = 32'd0;
    UNSIGNED_OP = 1'b0;
    RM = 3'd0;
    RESET = 1'b1;
    #1 RESET = 1'b0;
    #2;
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_result", RESULT, 32'd0);
    check("rst_inexact", {31'd0, INEXACT}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    vecs[0]  = '{32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 1'b0, 3'd0, 32'hBF80_0000, 1'b0};
    vecs[2]  = '{32'hFFFF_FFFF, 1'b1, 3'd0, 32'h4F80_0000, 1'b1};
    vecs[3]  = '{32'hFFFF_FFFF, 1'b1, 3'd1, 32'h4F7F_FFFF, 1'b1};
    vecs[4]  = '{32'h8000_0000, 1'b0, 3'd0, 32'hCF00_0000, 1'b0};
    vecs[5]  = '{32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000, 1'b0};
    vecs[6]  = '{32'h0100_0001, 1'b1, 3'd0, 32'h4B80_0000, 1'b1};
    vecs[7]  = '{32'h0100_0001, 1'b1, 3'd3, 32'h4B80_0001, 1'b1};
    vecs[8]  = '{32'h0100_0001, 1'b1, 3'd4, 32'h4B80_0001, 1'b1};
    vecs[9]  = '{32'h0100_0003, 1'b1, 3'd0, 32'h4B80_0002, 1'b1};
    vecs[10] = '{32'h0000_3039, 1'b0, 3'd0, 32'h4640_E400, 1'b0};
    vecs[11] = '{32'h8000_0001, 1'b0, 3'd2, 32'hCF00_0000, 1'b1};
    vecs[12] = '{32'h8000_0001, 1'b0, 3'd1, 32'hCEFF_FFFF, 1'b1};
    vecs[13] = '{32'h8000_0001, 1'b0, 3'd3, 32'hCEFF_FFFF, 1'b1};
    vecs[14] = '{32'h7FFF_FFFF, 1'b0, 3'd0, 32'h4F00_0000, 1'b1};
    vecs[15] = '{32'h0000_0003, 1'b0, 3'd5, 32'h4040_0000, 1'b0};
    vecs[16] = '{32'h0000_0000, 1'b1, 3'd3, 32'h0000_0000, 1'b0};

    for (int i = 0; i < 17; i++) convert(vecs[i], i);

    // START held for 20 cycles: only one operand per 8 cycles is taken.
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      DATA1 = 32'(i + 1) * 32'h0123_4567;
      UNSIGNED_OP = i[0];
      RM = 3'(i % 5);
      START = 1'b1;
      @(negedge CLK);
      if (DONE) dones++;
    end
    START = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("burst_done_count", 32'(dones), 32'd3);

    // Reset while in NORM step 2.
    @(negedge CLK);
    DATA1 = 32'h1234_5678;
    UNSIGNED_OP = 1'b0;
    RM = 3'd0;
    START = 1'b1;
    k = cyc + 1;
    @(negedge CLK);
    START = 1'b0;
    while (cyc < k + 2) @(negedge CLK);
    check("pre_rst_busy", {31'd0, BUSY}, 32'd1);
    check("pre_rst_result_nonzero", {31'd0, RESULT != 32'd0}, 32'd1);
    #1 RESET = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, BUSY}, 32'd0);
    check("async_rst_done", {31'd0, DONE}, 32'd0);
    check("async_rst_result", RESULT, 32'd0);
    check("async_rst_inexact", {31'd0, INEXACT}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);

    convert(vecs[2], 100);
    convert(vecs[10], 101);

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
